// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory stage of a simple in-order pipeline. Accepts one execute-stage op at
// a time, performs at most one data-memory access through a req/ack
// handshake, and presents the result to writeback as a one-cycle pulse.
//
// Parameters
//   DMEM_TIMEOUT    max cycles to wait for dmem_ack in ACCESS; 0 = wait forever
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    op handshake from execute (ready only in IDLE)
//   ex_*                 op fields: address/ALU result, store data, rd,
//                        reg-write, load, store, size, unsigned-load
//   dmem_req/we/addr/wdata/be   memory request, held stable in ACCESS
//   dmem_ack/dmem_rdata  memory completion and read word
//   out_valid            one-cycle writeback pulse (DONE state)
//   aluout/read_data/mem_to_reg/rd/reg_write/mem_err   writeback results
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] aluout,
    output logic [31:0] read_data,
    output logic        mem_to_reg,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Last wait-counter value before the access is declared timed out.
    localparam logic [31:0] TO_LAST = (DMEM_TIMEOUT == 0) ? 32'd0 : 32'(DMEM_TIMEOUT - 1);

    // Select the addressed byte/half of a read word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic        rw_pend_q, rw_pend_d;
    logic [31:0] alu_pend_q, alu_pend_d;
    logic [4:0]  rd_pend_q, rd_pend_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] read_data_q, read_data_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_err_q, mem_err_d;

    logic        mem_op_s;
    logic        bad_s;
    logic        timeout_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;

    assign mem_op_s  = ex_mem_read | ex_mem_write;
    // Misaligned, illegal-size or read+write ops never reach memory.
    assign bad_s     = mem_op_s & ((ex_mem_read & ex_mem_write) |
                                   (ex_mem_size == 2'b11) |
                                   ((ex_mem_size == 2'b01) & ex_aluout[0]) |
                                   ((ex_mem_size == 2'b10) & (ex_aluout[1:0] != 2'b00)));
    assign timeout_s = (DMEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Store lane replication and byte-enable generation from size/offset.
    always_comb begin
        wdata_s = ex_store_data;
        be_s    = 4'b1111;
        case (ex_mem_size)
            2'b00: begin
                wdata_s = {4{ex_store_data[7:0]}};
                be_s    = 4'b0001 << ex_aluout[1:0];
            end
            2'b01: begin
                wdata_s = {2{ex_store_data[15:0]}};
                be_s    = ex_aluout[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_s = ex_store_data;
                be_s    = 4'b1111;
            end
        endcase
    end

    // Next-state and result computation for the IDLE/ACCESS/DONE machine.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        load_d       = load_q;
        rw_pend_d    = rw_pend_q;
        alu_pend_d   = alu_pend_q;
        rd_pend_d    = rd_pend_q;
        aluout_d     = aluout_q;
        read_data_d  = read_data_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_err_d    = mem_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_op_s && !bad_s) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = 32'd0;
                        we_d       = ex_mem_write;
                        addr_d     = {ex_aluout[31:2], 2'b00};
                        wdata_d    = wdata_s;
                        be_d       = be_s;
                        size_d     = ex_mem_size;
                        off_d      = ex_aluout[1:0];
                        uns_d      = ex_mem_unsigned;
                        load_d     = ex_mem_read;
                        rw_pend_d  = ex_reg_write & ~ex_mem_write & (ex_rd != 5'd0);
                        alu_pend_d = ex_aluout;
                        rd_pend_d  = ex_rd;
                    end else begin
                        state_d      = ST_DONE;
                        aluout_d     = ex_aluout;
                        rd_d         = ex_rd;
                        read_data_d  = 32'd0;
                        mem_to_reg_d = 1'b0;
                        mem_err_d    = bad_s;
                        reg_write_d  = ex_reg_write & ~ex_mem_write & (ex_rd != 5'd0) & ~bad_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    state_d      = ST_DONE;
                    aluout_d     = alu_pend_q;
                    rd_d         = rd_pend_q;
                    read_data_d  = load_q ? load_extend(dmem_rdata, off_q, size_q, uns_q) : 32'd0;
                    mem_to_reg_d = load_q;
                    reg_write_d  = rw_pend_q;
                    mem_err_d    = 1'b0;
                end else if (timeout_s) begin
                    state_d      = ST_DONE;
                    aluout_d     = alu_pend_q;
                    rd_d         = rd_pend_q;
                    read_data_d  = 32'd0;
                    mem_to_reg_d = 1'b0;
                    reg_write_d  = 1'b0;
                    mem_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                // Writeback strobes are pulses; data fields keep their values.
                state_d     = ST_IDLE;
                reg_write_d = 1'b0;
                mem_err_d   = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                reg_write_d = 1'b0;
                mem_err_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            uns_q        <= 1'b0;
            load_q       <= 1'b0;
            rw_pend_q    <= 1'b0;
            alu_pend_q   <= 32'd0;
            rd_pend_q    <= 5'd0;
            aluout_q     <= 32'd0;
            read_data_q  <= 32'd0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            load_q       <= load_d;
            rw_pend_q    <= rw_pend_d;
            alu_pend_q   <= alu_pend_d;
            rd_pend_q    <= rd_pend_d;
            aluout_q     <= aluout_d;
            read_data_q  <= read_data_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign dmem_req   = (state_q == ST_ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign aluout     = aluout_q;
    assign read_data  = read_data_q;
    assign mem_to_reg = mem_to_reg_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;
    assign mem_err    = mem_err_q;

endmodule
